// File: rtl/uncache_access_unit.sv
// Uncached (MMIO) access unit, downstream of dcache address translation.
// Loads are issued as single-beat bus reads. Stores go through a one-entry
// store buffer and respond to the dcache as soon as they are buffered.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from dcache
//   req_paddr/store/size/
//   signed/wstrb/wdata         request attributes (paddr already translated)
//   flush                      cancels a pending load, never a buffered store
//   resp_valid/rdata/err       one-cycle response pulse to dcache
//   rd_req/rd_addr/rd_ready    bus read request channel
//   ret_valid/ret_data         bus read return
//   wr_req/addr/size/strb/data bus write request channel
//   wr_ready/wr_done           bus write accept and completion
//
// Read FSM
//   state  | meaning
//   R_IDLE | ready for a request (when store buffer is empty)
//   R_REQ  | rd_req asserted, waiting for rd_ready
//   R_WAIT | read accepted, waiting for ret_valid or timeout
//   R_RESP | resp_valid pulse (load data, timeout error or store ack)
// Write FSM
//   state  | meaning
//   W_IDLE | store buffer empty or not yet presented
//   W_REQ  | wr_req asserted from the buffer, waiting for wr_ready
//   W_WAIT | write accepted, waiting for wr_done or timeout
module uncache_access_unit #(
   parameter int unsigned BUS_TIMEOUT = 255,
   parameter logic [31:0] ERR_RDATA   = 32'hdead_beef
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_paddr,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ready,
   input  logic        ret_valid,
   input  logic [31:0] ret_data,
   output logic        wr_req,
   output logic [31:0] wr_addr,
   output logic [1:0]  wr_size,
   output logic [3:0]  wr_strb,
   output logic [31:0] wr_data,
   input  logic        wr_ready,
   input  logic        wr_done
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} rstate_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_WAIT = 2'd2} wstate_t;

   localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
   // With BUS_TIMEOUT = 0 this wraps, but tmo_hit is gated off in that case.
   localparam logic [CW-1:0] TMO_LAST = CW'(BUS_TIMEOUT - 1);

   rstate_t rstate, rnext;
   wstate_t wstate, wnext;

   logic        sb_valid;
   logic [31:0] sb_addr;
   logic [1:0]  sb_size;
   logic [3:0]  sb_strb;
   logic [31:0] sb_data;

   logic [29:0] ld_addr;
   logic [1:0]  ld_off;
   logic [1:0]  ld_size;
   logic        ld_signed;
   logic        drop;
   logic [31:0] resp_data;
   logic        resp_err_q;
   logic [CW-1:0] tmo_cnt;

   logic        accept;
   logic        in_wait;
   logic        wait_entry;
   logic        tmo_hit;
   logic [31:0] shifted;
   logic [31:0] ext;

   // A pending store blocks every new request, which keeps MMIO ordering.
   // rst gates req_ready so every output reads 0 while reset is held.
   assign req_ready  = rst && (rstate == R_IDLE) && !sb_valid;
   assign accept     = req_valid && req_ready;

   assign in_wait    = (rstate == R_WAIT) || (wstate == W_WAIT);
   assign wait_entry = ((rnext == R_WAIT) && (rstate != R_WAIT)) ||
                       ((wnext == W_WAIT) && (wstate != W_WAIT));
   assign tmo_hit    = (BUS_TIMEOUT != 0) && in_wait && (tmo_cnt == TMO_LAST);

   assign shifted = ret_data >> {ld_off, 3'b000};

   always_comb begin
      ext = shifted;
      case (ld_size)
         2'd0:    ext = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
         2'd1:    ext = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      rnext = rstate;
      case (rstate)
         R_IDLE: if (accept) rnext = req_store ? R_RESP : R_REQ;
         R_REQ: begin
            if (rd_ready)   rnext = R_WAIT;
            else if (flush) rnext = R_IDLE;
         end
         // A flushed load still consumes its return beat but skips R_RESP.
         R_WAIT: if (ret_valid || tmo_hit) rnext = (drop || flush) ? R_IDLE : R_RESP;
         R_RESP: rnext = R_IDLE;
         default: rnext = R_IDLE;
      endcase
   end

   always_comb begin
      wnext = wstate;
      case (wstate)
         W_IDLE:  if (sb_valid) wnext = W_REQ;
         W_REQ:   if (wr_ready) wnext = W_WAIT;
         W_WAIT:  if (wr_done || tmo_hit) wnext = W_IDLE;
         default: wnext = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstate     <= R_IDLE;
         ld_addr    <= '0;
         ld_off     <= '0;
         ld_size    <= '0;
         ld_signed  <= 1'b0;
         drop       <= 1'b0;
         resp_data  <= '0;
         resp_err_q <= 1'b0;
      end else begin
         rstate <= rnext;
         if (accept) begin
            drop <= 1'b0;
            if (req_store) begin
               resp_data  <= '0;
               resp_err_q <= 1'b0;
            end else begin
               ld_addr   <= req_paddr[31:2];
               ld_off    <= req_paddr[1:0];
               ld_size   <= req_size;
               ld_signed <= req_signed;
            end
         end
         if ((rstate == R_REQ) && rd_ready) drop <= flush;
         if (rstate == R_WAIT) begin
            if (flush) drop <= 1'b1;
            if (ret_valid) begin
               resp_data  <= ext;
               resp_err_q <= 1'b0;
            end else if (tmo_hit) begin
               resp_data  <= ERR_RDATA;
               resp_err_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate   <= W_IDLE;
         sb_valid <= 1'b0;
         sb_addr  <= '0;
         sb_size  <= '0;
         sb_strb  <= '0;
         sb_data  <= '0;
      end else begin
         wstate <= wnext;
         if (accept && req_store) begin
            sb_valid <= 1'b1;
            sb_addr  <= req_paddr;
            sb_size  <= req_size;
            sb_strb  <= req_wstrb;
            sb_data  <= req_wdata;
         end else if ((wstate == W_WAIT) && (wr_done || tmo_hit)) begin
            sb_valid <= 1'b0;
         end
      end
   end

   // Read and write waits never overlap, so one counter serves both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            tmo_cnt <= '0;
      else if (wait_entry) tmo_cnt <= '0;
      else if (in_wait)    tmo_cnt <= tmo_cnt + CW'(1);
   end

   assign rd_req     = (rstate == R_REQ);
   assign rd_addr    = {ld_addr, 2'b00};
   assign wr_req     = (wstate == W_REQ);
   assign wr_addr    = sb_addr;
   assign wr_size    = sb_size;
   assign wr_strb    = sb_strb;
   assign wr_data    = sb_data;
   assign resp_valid = (rstate == R_RESP) && !flush;
   assign resp_rdata = resp_valid ? resp_data : 32'h0;
   assign resp_err   = resp_valid && resp_err_q;

endmodule

// File: tb/tb_uncache_access_unit.sv
module tb_uncache_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_paddr = '0;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic [3:0]  req_wstrb = '0;
   logic [31:0] req_wdata = '0;
   logic        flush = 1'b0;
   logic        rd_ready = 1'b0;
   logic        ret_valid = 1'b0;
   logic [31:0] ret_data = '0;
   logic        wr_ready = 1'b0;
   logic        wr_done = 1'b0;

   logic        req_ready, resp_valid, resp_err, rd_req, wr_req;
   logic [31:0] resp_rdata, rd_addr, wr_addr, wr_data;
   logic [1:0]  wr_size;
   logic [3:0]  wr_strb;

   logic        t_req_ready, t_resp_valid, t_resp_err, t_rd_req, t_wr_req;
   logic [31:0] t_resp_rdata, t_rd_addr, t_wr_addr, t_wr_data;
   logic [1:0]  t_wr_size;
   logic [3:0]  t_wr_strb;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uncache_access_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
      .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata), .flush(flush),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .ret_valid(ret_valid), .ret_data(ret_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb),
      .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done)
   );

   // Second instance with a short timeout; sees the same stimulus.
   uncache_access_unit #(.BUS_TIMEOUT(4)) dut_t (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(t_req_ready), .req_paddr(req_paddr),
      .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata), .flush(flush),
      .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
      .rd_req(t_rd_req), .rd_addr(t_rd_addr), .rd_ready(rd_ready),
      .ret_valid(ret_valid), .ret_data(ret_data),
      .wr_req(t_wr_req), .wr_addr(t_wr_addr), .wr_size(t_wr_size), .wr_strb(t_wr_strb),
      .wr_data(t_wr_data), .wr_ready(wr_ready), .wr_done(wr_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Load with immediate rd_ready and immediate return; checks the R_RESP cycle.
   task automatic load_fast(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] d, input logic [31:0] exp,
                            input logic fl);
      tick();
      req_valid = 1'b1; req_store = 1'b0; req_paddr = a; req_size = sz; req_signed = sg;
      #1;
      tick();
      req_valid = 1'b0; rd_ready = 1'b1;
      #1;
      tick();
      rd_ready = 1'b0; ret_valid = 1'b1; ret_data = d;
      #1;
      tick();
      ret_valid = 1'b0; flush = fl;
      #1;
      if (fl) begin
         chkb({tag, "_flushed_valid"}, resp_valid, 1'b0);
      end else begin
         chkb({tag, "_valid"}, resp_valid, 1'b1);
         chk({tag, "_rdata"}, resp_rdata, exp);
      end
      flush = 1'b0;
   endtask

   initial begin
      #12;
      chkb("rst_req_ready", req_ready, 1'b0);
      chkb("rst_rd_req", rd_req, 1'b0);
      chkb("rst_wr_req", wr_req, 1'b0);
      chkb("rst_resp_valid", resp_valid, 1'b0);
      chkb("rst_t_req_ready", t_req_ready, 1'b0);
      rst = 1'b1;

      // Signed byte load, return three cycles into R_WAIT
      tick();
      req_valid = 1'b1; req_paddr = 32'hbfaf_8003; req_store = 1'b0;
      req_size = 2'd0; req_signed = 1'b1;
      #1 chkb("sb_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      #1;
      chkb("sb_rd_req", rd_req, 1'b1);
      chk("sb_rd_addr", rd_addr, 32'hbfaf_8000);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      #1 chkb("sb_rd_req_low", rd_req, 1'b0);
      tick();
      #1 chkb("sb_no_early_resp", resp_valid, 1'b0);
      tick();
      ret_valid = 1'b1; ret_data = 32'h80aa_bbcc;
      #1;
      tick();
      ret_valid = 1'b0;
      #1;
      chkb("sb_resp_valid", resp_valid, 1'b1);
      chk("sb_resp_rdata", resp_rdata, 32'hffff_ff80);
      chkb("sb_resp_err", resp_err, 1'b0);
      tick();
      #1;
      chkb("sb_pulse_end", resp_valid, 1'b0);
      chkb("sb_ready_again", req_ready, 1'b1);

      load_fast("uh",  32'hbfaf_0002, 2'd1, 1'b0, 32'h1234_5678, 32'h0000_1234, 1'b0);
      load_fast("sh",  32'hbfaf_0000, 2'd1, 1'b1, 32'h1234_8765, 32'hffff_8765, 1'b0);
      load_fast("ub1", 32'hbfaf_0001, 2'd0, 1'b0, 32'h1234_8765, 32'h0000_0087, 1'b0);
      load_fast("w",   32'hbfaf_0010, 2'd2, 1'b1, 32'hcafe_f00d, 32'hcafe_f00d, 1'b0);
      load_fast("rf",  32'hbfaf_0014, 2'd2, 1'b0, 32'h1111_2222, 32'h0, 1'b1);

      // Late ret_valid in R_IDLE is ignored
      tick();
      ret_valid = 1'b1; ret_data = 32'h5555_aaaa;
      #1;
      tick();
      ret_valid = 1'b0;
      #1;
      chkb("late_ret_no_resp", resp_valid, 1'b0);
      chkb("late_ret_ready", req_ready, 1'b1);

      // Store buffering and ordering
      tick();
      req_valid = 1'b1; req_store = 1'b1; req_paddr = 32'hbfaf_f020;
      req_size = 2'd0; req_wstrb = 4'b0001; req_wdata = 32'h0000_00ab;
      #1 chkb("st_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0; req_store = 1'b0;
      #1;
      chkb("st_resp_valid", resp_valid, 1'b1);
      chk("st_resp_rdata", resp_rdata, 32'h0);
      chkb("st_resp_err", resp_err, 1'b0);
      chkb("st_ready_blocked", req_ready, 1'b0);
      tick();
      #1;
      chkb("st_wr_req_c1", wr_req, 1'b1);
      chk("st_wr_addr", wr_addr, 32'hbfaf_f020);
      chk("st_wr_data", wr_data, 32'h0000_00ab);
      chk("st_wr_strb", {28'h0, wr_strb}, 32'h1);
      chk("st_wr_size", {30'h0, wr_size}, 32'h0);
      chkb("st_resp_over", resp_valid, 1'b0);
      tick();
      wr_ready = 1'b1;
      #1 chkb("st_wr_req_c2", wr_req, 1'b1);
      tick();
      wr_ready = 1'b0;
      req_valid = 1'b1; req_store = 1'b0; req_paddr = 32'hbfaf_0008;
      req_size = 2'd2; req_signed = 1'b0;
      #1;
      chkb("st_wr_req_low", wr_req, 1'b0);
      chkb("st_ready_wait1", req_ready, 1'b0);
      tick();
      wr_done = 1'b1;
      #1;
      chkb("st_ready_wait2", req_ready, 1'b0);
      chkb("st_load_held", rd_req, 1'b0);
      tick();
      wr_done = 1'b0;
      #1 chkb("st_ready_after_done", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      #1;
      chkb("ord_rd_req", rd_req, 1'b1);
      chk("ord_rd_addr", rd_addr, 32'hbfaf_0008);

      // Flush before the read handshake
      flush = 1'b1; rd_ready = 1'b0;
      tick();
      flush = 1'b0;
      #1;
      chkb("fr_rd_req_low", rd_req, 1'b0);
      chkb("fr_ready", req_ready, 1'b1);
      chkb("fr_no_resp", resp_valid, 1'b0);
      tick();
      #1 chkb("fr_no_resp2", resp_valid, 1'b0);

      // Flush in R_WAIT, return arrives four cycles later
      req_valid = 1'b1; req_paddr = 32'hbfaf_0018; req_size = 2'd2;
      tick();
      req_valid = 1'b0; rd_ready = 1'b1;
      #1;
      tick();
      rd_ready = 1'b0; flush = 1'b1;
      #1 chkb("fw_no_resp_f", resp_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         flush = 1'b0;
         #1;
         chkb("fw_no_resp", resp_valid, 1'b0);
         chkb("fw_ready_low", req_ready, 1'b0);
      end
      tick();
      ret_valid = 1'b1; ret_data = 32'h9999_9999;
      #1 chkb("fw_no_resp_ret", resp_valid, 1'b0);
      tick();
      ret_valid = 1'b0;
      #1;
      chkb("fw_ready_back", req_ready, 1'b1);
      chkb("fw_no_resp_after", resp_valid, 1'b0);
      tick();
      #1 chkb("fw_no_resp_after2", resp_valid, 1'b0);

      // Timeout on the short-timeout instance, then async reset in R_RESP
      req_valid = 1'b1; req_paddr = 32'hbfaf_0004; req_size = 2'd2;
      tick();
      req_valid = 1'b0; rd_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         tick();
         rd_ready = 1'b0;
         #1 chkb("to_not_yet", t_resp_valid, 1'b0);
      end
      tick();
      #1;
      chkb("to_resp_valid", t_resp_valid, 1'b1);
      chk("to_resp_rdata", t_resp_rdata, 32'hdead_beef);
      chkb("to_resp_err", t_resp_err, 1'b1);
      chkb("to_main_waiting", resp_valid, 1'b0);
      rst = 1'b0;
      #1;
      chkb("ar_t_resp_valid", t_resp_valid, 1'b0);
      chk("ar_t_resp_rdata", t_resp_rdata, 32'h0);
      chkb("ar_t_resp_err", t_resp_err, 1'b0);
      chkb("ar_main_rd_req", rd_req, 1'b0);
      #1 rst = 1'b1;

      // Async reset while a buffered store is presented: store is lost
      tick();
      req_valid = 1'b1; req_store = 1'b1; req_paddr = 32'hbfaf_0100;
      req_size = 2'd2; req_wstrb = 4'hf; req_wdata = 32'h0000_0012;
      #1;
      tick();
      req_valid = 1'b0; req_store = 1'b0;
      #1;
      tick();
      #1 chkb("ars_wr_req", wr_req, 1'b1);
      rst = 1'b0;
      #1 chkb("ars_wr_req_async", wr_req, 1'b0);
      #1 rst = 1'b1;
      tick();
      #1;
      chkb("ars_wr_req_gone", wr_req, 1'b0);
      chkb("ars_ready", req_ready, 1'b1);

      // Async reset while rd_req is high
      req_valid = 1'b1; req_paddr = 32'hbfaf_0200; req_size = 2'd2;
      tick();
      req_valid = 1'b0;
      #1 chkb("arr_rd_req", rd_req, 1'b1);
      rst = 1'b0;
      #1;
      chkb("arr_rd_req_async", rd_req, 1'b0);
      chk("arr_rd_addr", rd_addr, 32'h0);
      #1 rst = 1'b1;
      tick();
      #1 chkb("arr_rd_req_stays", rd_req, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
